// File: rtl/apb_master_bridge.sv
// APB4 master: turns one valid/ready request into a single SETUP/ACCESS transfer
// and returns its result on a valid/ready response channel, with an optional PREADY timeout.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             timeout_hit;

  always_comb begin
    wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == TO_LIMIT);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            psel      <= 1'b1;
            paddr     <= req_addr;
            pwrite    <= req_write;
            pwdata    <= req_wdata;
            pstrb     <= req_write ? req_strb : '0;
            pprot     <= req_prot;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready is tested first so completion beats a timeout on the same edge
          if (pready || timeout_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
            rsp_err     <= pready ? pslverr : 1'b1;
            rsp_timeout <= !pready;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a scripted APB slave and hand-computed expectations.
module tb_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int          TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .req_prot   (req_prot),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer; waits = pready-low ACCESS cycles before pready (>= TO means never),
  // hold = cycles rsp_ready stays low while a second request is pending.
  task automatic run_xfer(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                          input int waits, input logic [31:0] rdata_in, input logic slverr_in,
                          input int hold);
    logic [3:0]  exp_strb;
    logic        exp_to;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          acc;
    bit          done;
    exp_strb  = wr ? strb : 4'h0;
    exp_to    = (waits >= TO);
    exp_rdata = (wr || exp_to) ? 32'h0 : rdata_in;
    exp_err   = exp_to | slverr_in;

    @(negedge pclk);
    check({tag, ".idle_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    req_strb  = strb;
    req_prot  = prot;
    rsp_ready = (hold == 0);

    @(negedge pclk);
    req_valid = 1'b0;
    prdata    = rdata_in;
    check({tag, ".setup_psel"}, psel, 1);
    check({tag, ".setup_penable"}, penable, 0);
    check({tag, ".setup_paddr"}, paddr, addr);
    check({tag, ".setup_pstrb"}, pstrb, exp_strb);
    check({tag, ".setup_req_ready"}, req_ready, 0);

    acc  = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge pclk);
      if (penable) begin
        acc++;
        check({tag, ".acc_psel"}, psel, 1);
        check({tag, ".acc_paddr"}, paddr, addr);
        check({tag, ".acc_pwrite"}, pwrite, wr);
        check({tag, ".acc_pwdata"}, pwdata, wdata);
        check({tag, ".acc_pstrb"}, pstrb, exp_strb);
        check({tag, ".acc_pprot"}, pprot, prot);
        pready  = (acc > waits);
        pslverr = (acc > waits) ? slverr_in : 1'b0;
      end else begin
        done = 1'b1;
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    check({tag, ".access_bound"}, done, 1);
    check({tag, ".penable_cycles"}, acc, exp_to ? TO : waits + 1);
    check({tag, ".rsp_valid"}, rsp_valid, 1);
    check({tag, ".rsp_psel"}, {psel, penable}, 2'b00);
    check({tag, ".rsp_paddr"}, paddr, 0);
    check({tag, ".rsp_req_ready"}, req_ready, 0);
    check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".rsp_err"}, rsp_err, exp_err);
    check({tag, ".rsp_timeout"}, rsp_timeout, exp_to);

    if (hold > 0) begin
      req_valid = 1'b1;
      req_addr  = addr ^ 32'hFFFF_0000;
      for (int i = 0; i < hold; i++) begin
        @(negedge pclk);
        check({tag, ".hold_valid"}, rsp_valid, 1);
        check({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".hold_err"}, {rsp_err, rsp_timeout}, {exp_err, exp_to});
        check({tag, ".hold_req_ready"}, req_ready, 0);
        check({tag, ".hold_psel"}, psel, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end

    @(negedge pclk);
    check({tag, ".done_rsp_valid"}, rsp_valid, 0);
    check({tag, ".done_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    preset    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b1;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    @(negedge pclk);
    @(negedge pclk);
    check("reset.req_ready", req_ready, 0);
    check("reset.rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check("reset.rsp_rdata", rsp_rdata, 0);
    check("reset.psel_penable", {psel, penable, pwrite}, 3'b000);
    check("reset.paddr", paddr, 0);
    check("reset.pwdata", pwdata, 0);
    check("reset.pstrb_pprot", {pstrb, pprot}, 7'h00);
    preset = 1'b0;

    run_xfer("wr0",   32'h0000_1000, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'd0, 0,    32'h1234_5678, 1'b0, 0);
    run_xfer("rd3ws", 32'h0000_2004, 1'b0, 32'h1111_2222, 4'hF, 3'd2, 3,    32'hDEAD_BEEF, 1'b0, 0);
    run_xfer("wrerr", 32'h0000_3008, 1'b1, 32'h0F0F_F0F0, 4'h5, 3'd1, 1,    32'h5555_AAAA, 1'b1, 0);
    run_xfer("rdto",  32'h0000_4000, 1'b0, 32'h0,         4'h0, 3'd0, 1000, 32'hCAFE_F00D, 1'b0, 0);
    run_xfer("rd16",  32'h0000_4004, 1'b0, 32'h0,         4'h0, 3'd4, 15,   32'h0BAD_F00D, 1'b0, 0);
    run_xfer("hold",  32'h0000_5000, 1'b1, 32'h1357_9BDF, 4'h3, 3'd6, 0,    32'h2468_ACE0, 1'b0, 5);

    // reset while a read sits in ACCESS
    @(negedge pclk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_6000;
    req_write = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    check("midrst.in_access", {psel, penable}, 2'b11);
    #2 preset = 1'b1;
    #1;
    check("midrst.psel_penable", {psel, penable}, 2'b00);
    check("midrst.rsp_valid", rsp_valid, 0);
    check("midrst.req_ready", req_ready, 0);
    @(negedge pclk);
    check("midrst.held", {psel, penable, rsp_valid}, 3'b000);
    preset = 1'b0;

    run_xfer("rdpost", 32'h0000_6000, 1'b0, 32'h0, 4'hF, 3'd7, 2, 32'h600D_600D, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
